iec_fast_serial_host: RTL and testbench

Host-side endpoint for the 1581 burst (fast serial) protocol. It sits on the IEC bus directly opposite the drive and exchanges bytes with the drive's CIA serial port over the shared DATA line and the fast-clock (FCLK) line. It emulates an 8520-style serial shift register in both directions: it generates FCLK when transmitting and samples on FCLK rising edges when receiving. The byte-level valid/ready interface faces the host-side logic (C128-mode controller or test harness).

---
 rtl/iec_fast_serial_host.sv | 171 +++++++++++++++++
 tb/tb_iec_fast_serial_host.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iec_fast_serial_host.sv
// Host-side 1581 burst (fast serial) endpoint: shifts bytes MSB first over DATA/FCLK,
// driving FCLK when transmitting and sampling FCLK rising edges when receiving.
module iec_fast_serial_host #(
    parameter int HALF_PERIOD = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       listen,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy,
    input  logic       iec_data_i,
    input  logic       iec_fclk_i,
    output logic       iec_data_o,
    output logic       iec_fclk_o
);
    localparam int HPW = $clog2(HALF_PERIOD + 1);
    localparam int TOW = $clog2(TIMEOUT + 1);
    localparam logic [HPW-1:0] HP_LAST = HPW'(HALF_PERIOD - 1);
    localparam logic [HPW-1:0] HP_ONE  = HPW'(1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);
    localparam logic [TOW-1:0] TO_ONE  = TOW'(1);

    typedef enum logic [1:0] {IDLE, TX_LOW, TX_HIGH, RX} state_t;

    state_t         state, state_nx;
    logic [7:0]     shreg, shreg_nx, rx_data_nx, shift_in;
    logic [3:0]     bitcnt, bitcnt_nx;
    logic [HPW-1:0] hp_cnt, hp_cnt_nx;
    logic [TOW-1:0] to_cnt, to_cnt_nx;
    logic           tx_done_nx, rx_valid_nx, rx_err_nx;
    logic [1:0]     data_sync, fclk_sync;
    logic           fclk_prev, fclk_rise, data_bit;

    // Synchronisers idle at the released bus level; the edge flag and its DATA bit are
    // registered together so the sampled bit stays aligned with the FCLK rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_sync <= 2'b11;
            fclk_sync <= 2'b11;
            fclk_prev <= 1'b1;
            fclk_rise <= 1'b0;
            data_bit  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample pre-edge values, which is what makes this a shift chain.
            data_sync <= {data_sync[0], iec_data_i};
            fclk_sync <= {fclk_sync[0], iec_fclk_i};
            fclk_prev <= fclk_sync[1];
            fclk_rise <= fclk_sync[1] & ~fclk_prev;
            data_bit  <= data_sync[1];
        end
    end

    assign shift_in = {shreg[6:0], data_bit};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx    = state;
        shreg_nx    = shreg;
        bitcnt_nx   = bitcnt;
        hp_cnt_nx   = hp_cnt;
        to_cnt_nx   = to_cnt;
        rx_data_nx  = rx_data;
        tx_done_nx  = 1'b0;
        rx_valid_nx = 1'b0;
        rx_err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    shreg_nx  = tx_data;
                    bitcnt_nx = 4'd0;
                    hp_cnt_nx = '0;
                    state_nx  = TX_LOW;
                end else if (listen && fclk_rise) begin
                    shreg_nx  = shift_in;
                    bitcnt_nx = 4'd1;
                    to_cnt_nx = '0;
                    state_nx  = RX;
                end
            end
            TX_LOW: begin
                if (ce) begin
                    if (hp_cnt == HP_LAST) begin
                        hp_cnt_nx = '0;
                        state_nx  = TX_HIGH;
                    end else begin
                        hp_cnt_nx = hp_cnt + HP_ONE;
                    end
                end
            end
            TX_HIGH: begin
                if (ce) begin
                    if (hp_cnt == HP_LAST) begin
                        hp_cnt_nx = '0;
                        shreg_nx  = {shreg[6:0], 1'b0};
                        bitcnt_nx = bitcnt + 4'd1;
                        if (bitcnt_nx == 4'd8) begin
                            tx_done_nx = 1'b1;
                            state_nx   = IDLE;
                        end else begin
                            state_nx = TX_LOW;
                        end
                    end else begin
                        hp_cnt_nx = hp_cnt + HP_ONE;
                    end
                end
            end
            RX: begin
                if (fclk_rise) begin
                    shreg_nx  = shift_in;
                    bitcnt_nx = bitcnt + 4'd1;
                    to_cnt_nx = '0;
                    if (bitcnt == 4'd7) begin
                        rx_data_nx  = shift_in;
                        rx_valid_nx = 1'b1;
                        state_nx    = IDLE;
                    end
                end else if (ce) begin
                    if (to_cnt == TO_LAST) begin
                        rx_err_nx = 1'b1;
                        shreg_nx  = '0;
                        bitcnt_nx = 4'd0;
                        to_cnt_nx = '0;
                        state_nx  = IDLE;
                    end else begin
                        to_cnt_nx = to_cnt + TO_ONE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bitcnt   <= 4'd0;
            hp_cnt   <= '0;
            to_cnt   <= '0;
            rx_data  <= '0;
            tx_done  <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            bitcnt   <= bitcnt_nx;
            hp_cnt   <= hp_cnt_nx;
            to_cnt   <= to_cnt_nx;
            rx_data  <= rx_data_nx;
            tx_done  <= tx_done_nx;
            rx_valid <= rx_valid_nx;
            rx_err   <= rx_err_nx;
        end
    end

    // Bus drives decode straight from state so reset releases both lines without waiting for a clock.
    assign tx_ready   = (state == IDLE) && !listen;
    assign busy       = (state != IDLE);
    assign iec_fclk_o = (state != TX_LOW);
    assign iec_data_o = (state == TX_LOW || state == TX_HIGH) ? shreg[7] : 1'b1;

endmodule

// File: tb/tb_iec_fast_serial_host.sv
// Randomised bench for iec_fast_serial_host: a wired-AND bus model, a bit-level bus decoder
// for transmit and a last-completed-byte model for receive.
module tb_iec_fast_serial_host;
    localparam int HP = 2;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset, ce, listen, tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, tx_done, rx_valid, rx_err, busy;
    logic [7:0] rx_data;
    logic       iec_data_i, iec_fclk_i, iec_data_o, iec_fclk_o;
    logic       tb_data, tb_fclk;

    int         checks = 0, failures = 0;
    int         rxv_cnt = 0, rxe_cnt = 0, td_cnt = 0, guard_viol = 0, td_exp = 0;
    bit         guard = 0, ce_rand = 0;
    logic [7:0] last_rx = 8'h00, guard_tx = 8'h00;

    assign iec_data_i = iec_data_o & tb_data;
    assign iec_fclk_i = iec_fclk_o & tb_fclk;

    iec_fast_serial_host #(.HALF_PERIOD(HP), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ce(ce), .listen(listen),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_done(tx_done),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .busy(busy),
        .iec_data_i(iec_data_i), .iec_fclk_i(iec_fclk_i),
        .iec_data_o(iec_data_o), .iec_fclk_o(iec_fclk_o)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (rx_valid) rxv_cnt++;
        if (rx_err) rxe_cnt++;
        if (tx_done) td_cnt++;
        if (guard && tx_ready) guard_viol++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ce_rand) ce = 1'($urandom_range(0, 1));
    endtask

    task automatic tx_start(input logic [7:0] b, input bit hold, input logic [7:0] nb, input string tag);
        int w = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && w < 200) begin
            tick();
            w++;
        end
        check({tag, "_ready"}, 32'(tx_ready), 1);
        tick();
        if (hold) tx_data = nb;
        else tx_valid = 1'b0;
    endtask

    // Decodes the DUT's own bus drive from the first TX_LOW cycle up to tx_done.
    task automatic tx_watch(input logic [7:0] b, input bit rand_ce, input string tag);
        int         cyc = 0, ticks = 0, pulses = 0, run = 0, bad_runs = 0, bad_data = 0;
        logic [7:0] got = 8'h00;
        logic       prev_f = 1'b1;
        bit         done = 0;
        check({tag, "_first"}, 32'({busy, iec_fclk_o, iec_data_o}), 32'({1'b1, 1'b0, b[7]}));
        while (!done && cyc < 4000) begin
            ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!iec_fclk_o && prev_f) begin
                pulses++;
                got = {got[6:0], iec_data_o};
            end
            if (pulses > 0 && iec_data_o != got[0]) bad_data++;
            if (iec_fclk_o != prev_f && cyc > 0) begin
                if (run != HP) bad_runs++;
                run = 0;
            end
            run++;
            prev_f = iec_fclk_o;
            if (ce) ticks++;
            cyc++;
            tick();
            done = tx_done;
        end
        if (run != HP) bad_runs++;
        ce = 1'b1;
        check({tag, "_done_seen"}, 32'(done), 1);
        check({tag, "_bits"}, 32'(got), 32'(b));
        check({tag, "_pulses"}, pulses, 8);
        check({tag, "_ticks"}, ticks, 16 * HP);
        check({tag, "_data_stable"}, bad_data, 0);
        if (!rand_ce) begin
            check({tag, "_cycles"}, cyc, 16 * HP);
            check({tag, "_phase_len"}, bad_runs, 0);
        end
        check({tag, "_released"}, 32'({busy, iec_fclk_o, iec_data_o}), 32'(3'b011));
    endtask

    // Drives one byte as the drive would; guard_at switches direction before that bit index.
    task automatic rx_byte(input logic [7:0] b, input int guard_at, input string tag);
        int v0 = rxv_cnt, e0 = rxe_cnt, lat = 0;
        for (int n = 0; n < 8; n++) begin
            if (n == guard_at) begin
                listen   = 1'b0;
                tx_data  = guard_tx;
                tx_valid = 1'b1;
                guard    = 1'b1;
                #1;
                check({tag, "_guard_busy"}, 32'({busy, tx_ready}), 32'(2'b10));
            end
            tb_fclk = 1'b0;
            tb_data = b[7-n];
            repeat (4) tick();
            if (n == 7) check({tag, "_hold_prev"}, 32'(rx_data), 32'(last_rx));
            tb_fclk = 1'b1;
            if (n < 7) repeat (4) tick();
        end
        while (lat < 12 && !rx_valid) begin
            tick();
            lat++;
        end
        guard = 1'b0;
        check({tag, "_latency"}, lat, 4);
        last_rx = b;
        check({tag, "_data"}, 32'(rx_data), 32'(last_rx));
        if (guard_at > 7) begin
            repeat (4) tick();
            check({tag, "_one_valid"}, rxv_cnt - v0, 1);
            check({tag, "_no_err"}, rxe_cnt - e0, 0);
        end
    endtask

    task automatic rx_timeout(input logic [7:0] b, input int nbits, input string tag);
        int v0 = rxv_cnt, e0 = rxe_cnt, lat = 0;
        for (int n = 0; n < nbits; n++) begin
            tb_fclk = 1'b0;
            tb_data = b[7-n];
            repeat (4) tick();
            tb_fclk = 1'b1;
            if (n < nbits - 1) repeat (4) tick();
        end
        while (lat < TO + 40 && !rx_err) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, TO + 4);
        check({tag, "_data_kept"}, 32'(rx_data), 32'(last_rx));
        repeat (2) tick();
        check({tag, "_idle"}, 32'(busy), 0);
        check({tag, "_one_err"}, rxe_cnt - e0, 1);
        check({tag, "_no_valid"}, rxv_cnt - v0, 0);
    endtask

    initial begin
        logic [7:0] b;
        int         lows, td0;
        logic       prev_f;

        reset = 1'b1; ce = 1'b1; listen = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        tb_fclk = 1'b1; tb_data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 32'({tx_ready, busy, tx_done, rx_valid, rx_err, iec_fclk_o, iec_data_o}),
              32'(7'b1000011));
        check("rst_rx_data", 32'(rx_data), 0);
        listen = 1'b1;
        #1;
        check("rst_ready_listen", 32'(tx_ready), 0);
        listen = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        tx_start(8'hA5, 0, 8'h00, "tx_a5");
        tx_watch(8'hA5, 0, "tx_a5");
        td_exp++;
        tick();
        check("tx_a5_pulse_width", 32'({tx_done, iec_fclk_o, iec_data_o}), 32'(3'b011));

        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            tx_start(b, 0, 8'h00, "tx_rand");
            tx_watch(b, 1, "tx_rand");
            td_exp++;
            repeat (2) tick();
        end

        tx_start(8'h00, 1, 8'hFF, "b2b0");
        tx_watch(8'h00, 0, "b2b0");
        td_exp++;
        check("b2b_ready", 32'(tx_ready), 1);
        tick();
        tx_valid = 1'b0;
        tx_watch(8'hFF, 0, "b2b1");
        td_exp++;

        repeat (6) tick();
        listen = 1'b1;
        repeat (2) tick();
        rx_byte(8'h3C, 99, "rx_3c");

        ce_rand = 1'b1;
        for (int i = 0; i < 4; i++) rx_byte(8'($urandom), 99, "rx_rand");
        ce_rand = 1'b0;
        ce = 1'b1;

        rx_timeout(8'($urandom), 3, "rx_to");
        rx_byte(8'h81, 99, "rx_81");

        guard_tx = 8'($urandom);
        rx_byte(8'($urandom), 2, "guard_rx");
        check("guard_accept", 32'(tx_ready), 1);
        tick();
        tx_valid = 1'b0;
        tx_watch(guard_tx, 0, "guard_tx");
        td_exp++;
        tick();
        check("guard_no_early_ready", guard_viol, 0);

        repeat (6) tick();
        tx_start(8'h5A, 0, 8'h00, "rst_mid");
        lows = 0;
        prev_f = 1'b1;
        for (int i = 0; i < 200 && lows < 5; i++) begin
            if (!iec_fclk_o && prev_f) lows++;
            prev_f = iec_fclk_o;
            if (lows < 5) tick();
        end
        check("rst_mid_reach_bit4", lows, 5);
        td0 = td_cnt;
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_release", 32'({busy, tx_ready, iec_fclk_o, iec_data_o}), 32'(4'b0111));
        repeat (3) tick();
        check("rst_mid_no_done", td_cnt - td0, 0);
        reset = 1'b0;
        repeat (2) tick();
        tx_start(8'hFF, 0, 8'h00, "post_rst");
        tx_watch(8'hFF, 0, "post_rst");
        td_exp++;
        repeat (3) tick();

        check("tx_done_total", td_cnt, td_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
